// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: ROM address/data, redirect/stall control,
// and the IF/ID pipeline register outputs.
interface instruction_fetch_unit_if;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic [31:0] IfId_Inst;
    logic [31:0] IfId_Pc;
    logic [31:0] IfId_PcPlus4;
    logic        IfId_Valid;
    logic        Halted;
    logic        MisalignErr;

    modport master (
        output Addr,
        input  Inst,
        input  Stall,
        input  Redirect,
        input  RedirectPc,
        output IfId_Inst,
        output IfId_Pc,
        output IfId_PcPlus4,
        output IfId_Valid,
        output Halted,
        output MisalignErr
    );

    modport slave (
        input  Addr,
        output Inst,
        output Stall,
        output Redirect,
        output RedirectPc,
        input  IfId_Inst,
        input  IfId_Pc,
        input  IfId_PcPlus4,
        input  IfId_Valid,
        input  Halted,
        input  MisalignErr
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, ROM addressing and the IF/ID register,
// with stall, redirect/flush, halt detection and misalign flag.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'h0000_000C,
    parameter bit          HALT_EN   = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Clrn,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pcp4;
    logic        r_ifid_valid;
    logic        r_misalign;

    logic        w_redirect;
    logic        w_fetch;
    logic        w_halt_hit;
    logic        w_drain;
    logic        w_halted;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) r_state <= S_BOOT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_BOOT:   w_state_nxt = S_RUN;
            S_RUN:    if (w_halt_hit) w_state_nxt = S_HALTED;
            S_HALTED: if (bus.Redirect) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_BOOT;
        endcase
    end

    // BOOT ignores every control input; redirect beats stall elsewhere
    always_comb begin
        w_redirect = 1'b0;
        w_fetch    = 1'b0;
        w_drain    = 1'b0;
        w_halted   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_redirect = bus.Redirect;
                w_fetch    = !bus.Redirect && !bus.Stall;
            end
            S_HALTED: begin
                w_halted   = 1'b1;
                w_redirect = bus.Redirect;
                w_drain    = !bus.Redirect && !bus.Stall;
            end
            default: ;
        endcase
        w_halt_hit = w_fetch && HALT_EN && (bus.Inst == HALT_INST);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_pc         <= RESET_PC;
            r_ifid_inst  <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pcp4  <= 32'd0;
            r_ifid_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else if (w_redirect) begin
            r_pc         <= {bus.RedirectPc[31:2], 2'b00};
            r_ifid_inst  <= 32'd0;
            r_ifid_valid <= 1'b0;
            if (bus.RedirectPc[1:0] != 2'b00) r_misalign <= 1'b1;
        end else if (w_fetch) begin
            r_ifid_inst  <= bus.Inst;
            r_ifid_pc    <= r_pc;
            r_ifid_pcp4  <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
            if (!w_halt_hit) r_pc <= w_pc_plus4;
        end else if (w_drain) begin
            r_ifid_valid <= 1'b0;
        end
    end

    assign bus.Addr         = r_pc;
    assign bus.IfId_Inst    = r_ifid_inst;
    assign bus.IfId_Pc      = r_ifid_pc;
    assign bus.IfId_PcPlus4 = r_ifid_pcp4;
    assign bus.IfId_Valid   = r_ifid_valid;
    assign bus.Halted       = w_halted;
    assign bus.MisalignErr  = r_misalign;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: ROM model drives Inst from Addr[6:2];
// second instance covers RESET_PC wrap and mid-cycle reset.
module tb_instruction_fetch_unit;

    logic Clk = 1'b0;
    logic Clrn_a = 1'b1;
    logic Clrn_b = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    logic [31:0] rom [32];

    instruction_fetch_unit_if bus_a ();
    instruction_fetch_unit_if bus_b ();

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .HALT_INST (32'h0000_000C),
        .HALT_EN   (1'b1)
    ) u_dut_a (
        .Clk  (Clk),
        .Clrn (Clrn_a),
        .bus  (bus_a.master)
    );

    instruction_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFFC),
        .HALT_INST (32'h0000_000C),
        .HALT_EN   (1'b1)
    ) u_dut_b (
        .Clk  (Clk),
        .Clrn (Clrn_b),
        .bus  (bus_b.master)
    );

    always #5 Clk = ~Clk;

    assign bus_a.Inst = rom[bus_a.Addr[6:2]];
    assign bus_b.Inst = rom[bus_b.Addr[6:2]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_a();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic v,
                            input logic [31:0] addr);
        chk({tag, ".inst"}, bus_a.IfId_Inst, inst);
        chk({tag, ".pc"}, bus_a.IfId_Pc, pc);
        chk({tag, ".pcp4"}, bus_a.IfId_PcPlus4, pc + 32'd4);
        chk({tag, ".valid"}, {31'd0, bus_a.IfId_Valid}, {31'd0, v});
        chk({tag, ".addr"}, bus_a.Addr, addr);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013;
        rom[0] = 32'h8C02_0001;
        rom[1] = 32'h8C03_0002;
        rom[2] = 32'h0043_0020;
        rom[3] = 32'h0000_000C;
        bus_a.Stall = 1'b0;
        bus_a.Redirect = 1'b0;
        bus_a.RedirectPc = 32'd0;
        bus_b.Stall = 1'b0;
        bus_b.Redirect = 1'b0;
        bus_b.RedirectPc = 32'd0;

        #1;
        Clrn_a = 1'b0;
        Clrn_b = 1'b0;
        #1;
        chk("rst.addr", bus_a.Addr, 32'h0);
        chk("rst.inst", bus_a.IfId_Inst, 32'h0);
        chk("rst.pc", bus_a.IfId_Pc, 32'h0);
        chk("rst.pcp4", bus_a.IfId_PcPlus4, 32'h0);
        chk("rst.valid", {31'd0, bus_a.IfId_Valid}, 32'd0);
        chk("rst.halted", {31'd0, bus_a.Halted}, 32'd0);
        chk("rst.mis", {31'd0, bus_a.MisalignErr}, 32'd0);
        chk("rstb.addr", bus_b.Addr, 32'hFFFF_FFFC);

        edge_a();
        edge_a();
        Clrn_a = 1'b1;
        // BOOT edge must ignore redirect and stall
        bus_a.Stall = 1'b1;
        bus_a.Redirect = 1'b1;
        bus_a.RedirectPc = 32'h0000_0042;
        edge_a();
        bus_a.Stall = 1'b0;
        bus_a.Redirect = 1'b0;
        chk("boot.addr", bus_a.Addr, 32'h0);
        chk("boot.valid", {31'd0, bus_a.IfId_Valid}, 32'd0);
        chk("boot.mis", {31'd0, bus_a.MisalignErr}, 32'd0);

        edge_a();
        chk_ifid("f0", 32'h8C02_0001, 32'h0, 1'b1, 32'h4);

        bus_a.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_a();
            chk_ifid("stall", 32'h8C02_0001, 32'h0, 1'b1, 32'h4);
        end
        bus_a.Stall = 1'b0;
        edge_a();
        chk_ifid("f1", 32'h8C03_0002, 32'h4, 1'b1, 32'h8);
        edge_a();
        chk_ifid("f2", 32'h0043_0020, 32'h8, 1'b1, 32'hC);

        bus_a.Stall = 1'b1;
        bus_a.Redirect = 1'b1;
        bus_a.RedirectPc = 32'h0000_0008;
        edge_a();
        bus_a.Stall = 1'b0;
        bus_a.Redirect = 1'b0;
        chk_ifid("rdst", 32'h0, 32'h8, 1'b0, 32'h8);
        edge_a();
        chk_ifid("rdst2", 32'h0043_0020, 32'h8, 1'b1, 32'hC);

        bus_a.Redirect = 1'b1;
        bus_a.RedirectPc = 32'h0000_000A;
        edge_a();
        bus_a.Redirect = 1'b0;
        chk("mis.addr", bus_a.Addr, 32'h8);
        chk("mis.flag", {31'd0, bus_a.MisalignErr}, 32'd1);
        chk("mis.valid", {31'd0, bus_a.IfId_Valid}, 32'd0);
        edge_a();
        chk_ifid("f2b", 32'h0043_0020, 32'h8, 1'b1, 32'hC);

        edge_a();
        chk_ifid("halt", 32'h0000_000C, 32'hC, 1'b1, 32'hC);
        chk("halt.h", {31'd0, bus_a.Halted}, 32'd1);
        edge_a();
        chk_ifid("hdrain", 32'h0000_000C, 32'hC, 1'b0, 32'hC);
        chk("hdrain.h", {31'd0, bus_a.Halted}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            edge_a();
            chk("mis.sticky", {31'd0, bus_a.MisalignErr}, 32'd1);
        end
        chk("hold.addr", bus_a.Addr, 32'hC);
        chk("hold.h", {31'd0, bus_a.Halted}, 32'd1);

        bus_a.Redirect = 1'b1;
        bus_a.RedirectPc = 32'h0;
        edge_a();
        bus_a.Redirect = 1'b0;
        chk("resume.h", {31'd0, bus_a.Halted}, 32'd0);
        chk("resume.addr", bus_a.Addr, 32'h0);
        chk("resume.mis", {31'd0, bus_a.MisalignErr}, 32'd1);
        edge_a();
        chk_ifid("resume", 32'h8C02_0001, 32'h0, 1'b1, 32'h4);

        Clrn_a = 1'b0;
        #1;
        chk("clr.mis", {31'd0, bus_a.MisalignErr}, 32'd0);
        chk("clr.addr", bus_a.Addr, 32'h0);
        chk("clr.valid", {31'd0, bus_a.IfId_Valid}, 32'd0);

        Clrn_b = 1'b1;
        @(posedge Clk);
        #1;
        chk("b.boot", bus_b.Addr, 32'hFFFF_FFFC);
        @(posedge Clk);
        #1;
        chk("b.addr", bus_b.Addr, 32'h0);
        chk("b.pc", bus_b.IfId_Pc, 32'hFFFF_FFFC);
        chk("b.pcp4", bus_b.IfId_PcPlus4, 32'h0);
        chk("b.inst", bus_b.IfId_Inst, 32'h0000_0013);
        #2;
        Clrn_b = 1'b0;
        #1;
        chk("b.rst.inst", bus_b.IfId_Inst, 32'h0);
        chk("b.rst.pc", bus_b.IfId_Pc, 32'h0);
        chk("b.rst.pcp4", bus_b.IfId_PcPlus4, 32'h0);
        chk("b.rst.valid", {31'd0, bus_b.IfId_Valid}, 32'd0);
        chk("b.rst.addr", bus_b.Addr, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
